// File: rtl/load_store_sequencer.sv
// Single-outstanding load/store sequencer between execution and the data-memory port.
// Define MIST1032ISA_LDST_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of issuing them.
module load_store_sequencer #(
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic                iEXE_REQ,
  output logic                oEXE_BUSY,
  input  logic                iEXE_RW,
  input  logic [1:0]          iEXE_SIZE,
  input  logic [3:0]          iEXE_AFE_CODE,
  input  logic [P_ADDR_W-1:0] iEXE_ADDR,
  input  logic [P_DATA_W-1:0] iEXE_DATA,
  output logic                oMEM_REQ,
  input  logic                iMEM_BUSY,
  output logic                oMEM_RW,
  output logic [P_ADDR_W-1:0] oMEM_ADDR,
  output logic [3:0]          oMEM_MASK,
  output logic [P_DATA_W-1:0] oMEM_DATA,
  input  logic                iMEM_VALID,
  input  logic [P_DATA_W-1:0] iMEM_DATA,
  output logic                oDONE_VALID,
  output logic [P_DATA_W-1:0] oDONE_DATA,
  output logic                oDONE_FAULT
);

  localparam logic [3:0] AFE_LDST_NONE      = 4'h0;
  localparam logic [3:0] AFE_LDST_SEXT8_32  = 4'h1;
  localparam logic [3:0] AFE_LDST_SEXT16_32 = 4'h2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  state_t        state;
  logic          req_rw;
  logic [1:0]    req_size;
  logic [3:0]    req_afe;
  logic [1:0]    req_lane;

  logic          accept;
  logic          misaligned_c;
  logic [3:0]    mask_c;
  logic [P_DATA_W-1:0] wdata_c;

  assign accept = iEXE_REQ && !oEXE_BUSY && !iFLUSH && (state == ST_IDLE);

`ifdef MIST1032ISA_LDST_ALIGN_CHECK_EN
  // Size 3 is treated as a word, so bit 1 of the size covers both word encodings.
  assign misaligned_c = ((iEXE_SIZE == 2'd1) && iEXE_ADDR[0]) ||
                        (iEXE_SIZE[1] && (iEXE_ADDR[1:0] != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mask_c  = 4'b1111;
    wdata_c = iEXE_DATA;
    case (iEXE_SIZE)
      2'd0: begin
        mask_c  = 4'b0001 << iEXE_ADDR[1:0];
        wdata_c = {4{iEXE_DATA[7:0]}};
      end
      2'd1: begin
        mask_c  = 4'b0011 << {iEXE_ADDR[1], 1'b0};
        wdata_c = {2{iEXE_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane-align the read word, zero-fill to the access size, then apply the AFE.
  function automatic logic [P_DATA_W-1:0] align_load(
    input logic [P_DATA_W-1:0] d,
    input logic [1:0]          size,
    input logic [1:0]          lane,
    input logic [3:0]          afe
  );
    logic [P_DATA_W-1:0] s;
    case (size)
      2'd0:    s = (d >> {lane, 3'b000}) & 32'h0000_00FF;
      2'd1:    s = (d >> {lane[1], 4'b0000}) & 32'h0000_FFFF;
      default: s = d;
    endcase
    case (afe)
      AFE_LDST_SEXT8_32:  s = {{24{s[7]}}, s[7:0]};
      AFE_LDST_SEXT16_32: s = {{16{s[15]}}, s[15:0]};
      AFE_LDST_NONE:      ;
      default:            ;
    endcase
    return s;
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state       <= ST_IDLE;
      oEXE_BUSY   <= 1'b0;
      oMEM_REQ    <= 1'b0;
      oMEM_RW     <= 1'b0;
      oMEM_ADDR   <= '0;
      oMEM_MASK   <= 4'b0000;
      oMEM_DATA   <= '0;
      oDONE_VALID <= 1'b0;
      oDONE_DATA  <= '0;
      oDONE_FAULT <= 1'b0;
      req_rw      <= 1'b0;
      req_size    <= 2'd0;
      req_afe     <= 4'h0;
      req_lane    <= 2'd0;
    end else begin
      oDONE_VALID <= 1'b0;
      oDONE_FAULT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_rw   <= iEXE_RW;
            req_size <= iEXE_SIZE;
            req_afe  <= iEXE_AFE_CODE;
            req_lane <= iEXE_ADDR[1:0];
            if (misaligned_c) begin
              oDONE_VALID <= 1'b1;
              oDONE_FAULT <= 1'b1;
              oDONE_DATA  <= '0;
            end else begin
              state     <= ST_REQ;
              oEXE_BUSY <= 1'b1;
              oMEM_REQ  <= 1'b1;
              oMEM_RW   <= iEXE_RW;
              oMEM_ADDR <= {iEXE_ADDR[P_ADDR_W-1:2], 2'b00};
              oMEM_MASK <= mask_c;
              oMEM_DATA <= wdata_c;
            end
          end
        end
        ST_REQ: begin
          if (!iMEM_BUSY) begin
            // Handshake taken: a flush now must still swallow the response.
            oMEM_REQ <= 1'b0;
            state    <= iFLUSH ? ST_DRAIN : ST_WAIT;
          end else if (iFLUSH) begin
            oMEM_REQ  <= 1'b0;
            oEXE_BUSY <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (iMEM_VALID) begin
            state     <= ST_IDLE;
            oEXE_BUSY <= 1'b0;
            if (!iFLUSH) begin
              oDONE_VALID <= 1'b1;
              oDONE_DATA  <= req_rw ? '0 : align_load(iMEM_DATA, req_size, req_lane, req_afe);
            end
          end else if (iFLUSH) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (iMEM_VALID) begin
            state     <= ST_IDLE;
            oEXE_BUSY <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
Single-outstanding load/store controller between the execution stage and the data-memory port.
- Accepts one access from execution and issues it to memory as a word-aligned request with a byte mask.
- Waits for the memory response, then lane-aligns load data and applies the load/store AFE (sign/zero extension) under registered control.
- Returns one result beat to writeback and supports pipeline flush at any point.

Parameters:
P_ADDR_W, 32, address width (bits).
P_DATA_W, 32, data width (bits; fixed at 32, lanes are 8-bit).

Ports:
iCLOCK  in  1  core clock
iRESET_SYNC  in  1  synchronous reset, active-high
iFLUSH  in  1  cancel current/pending access
iEXE_REQ  in  1  access request
oEXE_BUSY  out  1  sequencer cannot accept (state != IDLE)
iEXE_RW  in  1  0=load, 1=store
iEXE_SIZE  in  2  0=byte, 1=half, 2=word, 3=reserved(treated as word)
iEXE_AFE_CODE  in  4  AFE_LDST_* code (NONE/SEXT8_32/SEXT16_32)
iEXE_ADDR  in  32  byte address
iEXE_DATA  in  32  store data (right-justified)
oMEM_REQ  out  1  memory request
iMEM_BUSY  in  1  memory stall; request held while high
oMEM_RW  out  1  0=read, 1=write
oMEM_ADDR  out  32  {addr[31:2],2'b00}
oMEM_MASK  out  4  byte-enable, lane0 = bits[7:0]
oMEM_DATA  out  32  lane-replicated store data
iMEM_VALID  in  1  response / store ack
iMEM_DATA  in  32  read data
oDONE_VALID  out  1  one-cycle result strobe
oDONE_DATA  out  32  extended load data (0 for stores)
oDONE_FAULT  out  1  alignment fault (only with option)

Behaviour:
- Reset (sync): state=IDLE; oEXE_BUSY, oMEM_REQ, oMEM_RW, oDONE_VALID, oDONE_FAULT = 0; oMEM_ADDR, oMEM_MASK, oMEM_DATA, oDONE_DATA = 0. Reset mid-access abandons it; a later iMEM_VALID for it is ignored.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: acceptance when iEXE_REQ & !oEXE_BUSY & !iFLUSH (cycle T). All request fields are latched at T; the state becomes REQ and oMEM_REQ=1 from T+1.
- REQ: oMEM_REQ and the address/mask/data outputs are held stable while iMEM_BUSY=1. The first cycle with iMEM_BUSY=0 is the handshake; then state=WAIT and oMEM_REQ=0 next cycle.
- WAIT: on iMEM_VALID the result is registered; oDONE_VALID=1 on the next cycle for exactly one cycle, and the state returns to IDLE the same cycle. Back-to-back acceptance is allowed in the cycle oDONE_VALID is high. Minimum latency is accept→done = 3 cycles (T+1 req, T+2 valid, T+3 done) with zero memory wait.
- Mask rules:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load path:
  - Shift right by lane: byte shifts by addr[1:0]*8; half shifts by addr[1]*16.
  - Zero-fill to size.
  - Then apply AFE: NONE passes through; SEXT8_32 replicates bit7; SEXT16_32 replicates bit15; other codes pass through.
- Half with addr[0]=1 uses lane addr[1]; the low address bit is ignored (option below faults instead).
- iFLUSH:
  - IDLE: blocks acceptance that cycle.
  - REQ before handshake: withdraw oMEM_REQ next cycle, go to IDLE, no oDONE_VALID.
  - REQ on the handshake cycle or in WAIT: go to DRAIN.
  - DRAIN: oEXE_BUSY=1; consume iMEM_VALID silently, then IDLE.
  - A flush coinciding with iMEM_VALID in WAIT suppresses oDONE_VALID and returns to IDLE.
- iMEM_VALID in IDLE/REQ is ignored.

Optional Feature:
Macro: MIST1032ISA_LDST_ALIGN_CHECK_EN.
- Defined:
  - A misaligned access (half with addr[0]=1; word with addr[1:0]!=0) is accepted but issues no memory request.
  - The state goes directly to IDLE via a one-cycle result: oDONE_VALID=1 and oDONE_FAULT=1 at T+1, with oDONE_DATA=0.
  - oDONE_FAULT is 0 on all other results.
- Undefined: no check; oDONE_FAULT is tied 0 and misaligned accesses follow the lane rules above.

Test Plan:
- Load byte, addr=0x1003, SEXT8_32, iMEM_DATA=0x80112233, no stall → oMEM_ADDR=0x1000, mask=4'b1000, oDONE_DATA=0xFFFFFF80 at T+3.
- Load half, addr=0x2002, NONE, iMEM_DATA=0x9ABC1234 → mask=4'b1100, oDONE_DATA=0x00009ABC. Repeat with SEXT16_32 → 0xFFFF9ABC.
- Store byte, addr=0x31, data=0x5A, iMEM_BUSY high 4 cycles → oMEM_REQ held 5 cycles with stable outputs, mask=4'b0010, oMEM_DATA=0x5A5A5A5A. Ack gives oDONE_VALID=1, oDONE_DATA=0.
- iFLUSH in WAIT, iMEM_VALID 2 cycles later → no oDONE_VALID, oEXE_BUSY high until the cycle after iMEM_VALID. A next request is then accepted normally.
- Back-to-back word loads 0x0 and 0x4 issued on the oDONE_VALID cycle → two results in order, no lost or duplicated strobe. Reset asserted in REQ → all outputs 0 next cycle.
- With MIST1032ISA_LDST_ALIGN_CHECK_EN: word load addr=0x6 → no oMEM_REQ, oDONE_VALID=oDONE_FAULT=1 at T+1.
